// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment types and constants for the 7-segment scan driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Entry n holds the active-low pattern for hex digit n (index 0 is the rightmost slice).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// seven_segment_scan_driver_if: data/control and display-pin bundle of the scan driver.
// master = system side that supplies data, slave = the driver itself.
interface seven_segment_scan_driver_if
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   dataInput;
  logic [NUM_DIGITS-1:0]     blankMask;
  logic [NUM_DIGITS-1:0]     digitSelect;
  seg_t                      controlOutput;
  logic                      frameDone;
  logic                      pending;

  modport master (
    output enable, load, dataInput, blankMask,
    input  digitSelect, controlOutput, frameDone, pending
  );

  modport slave (
    input  enable, load, dataInput, blankMask,
    output digitSelect, controlOutput, frameDone, pending
  );

endinterface

// File: rtl/seven_seg_hex_decoder.sv
// seven_seg_hex_decoder: combinational hex nibble to active-low segment pattern.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    seg = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode digits.
// Loaded data waits in a shadow register and is promoted only at frame wrap, so a frame
// never mixes old and new digits. All outputs are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN - blank digits above the most significant
// nonzero nibble (digit 0 is always shown).
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 50000
) (
  input logic                        clock,
  input logic                        reset,
  seven_segment_scan_driver_if.slave bus
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned PRESC_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic [DATA_W-1:0]     active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] digit_select_q, digit_select_d;
  seg_t                  control_output_q, control_output_d;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            sel_nibble;
  logic                  sel_blank;
  seg_t                  hex_seg;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] nz_above;
  logic                  nz_run;
  logic                  sel_nz;
`endif

  // Prescaler and digit index: a slot is CLK_DIV clocks; a frame is NUM_DIGITS slots.
  always_comb begin
    slot_end = (presc_q == PRESC_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    presc_d  = slot_end ? '0 : presc_q + PRESC_W'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow/active data: a load coinciding with the wrap bypasses the shadow stage.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = wrap;
    if (bus.load) begin
      shadow_d = bus.dataInput;
      if (wrap) begin
        active_d  = bus.dataInput;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Per digit: is any nibble at this position or above nonzero (digit 0 forced visible).
  always_comb begin
    nz_run   = 1'b0;
    nz_above = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nz_run = nz_run | (|active_d[4*(NUM_DIGITS-1-i) +: 4]);
      nz_above[NUM_DIGITS-1-i] = nz_run;
    end
    nz_above[0] = 1'b1;
  end
`endif

  // Select the nibble and per-digit attributes of the digit shown in the next cycle.
  // Outputs are built from next-state values so the registered pins line up with state.
  always_comb begin
    sel_nibble = '0;
    sel_blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    sel_nz     = 1'b1;
`endif
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx_d) begin
        sel_nibble = active_d[4*k +: 4];
        sel_blank  = bus.blankMask[k];
`ifdef LEADING_ZERO_BLANK_EN
        sel_nz     = nz_above[k];
`endif
      end
    end
  end

  seven_seg_hex_decoder u_hex_decoder (
    .nibble (sel_nibble),
    .seg    (hex_seg)
  );

  // Segment priority (dash, blank mask, optional zero suppression, hex) and anti-ghost select.
  always_comb begin
    if (!bus.enable) begin
      control_output_d = SEG_DASH;
    end else if (sel_blank) begin
      control_output_d = SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
    end else if (!sel_nz) begin
      control_output_d = SEG_BLANK;
`endif
    end else begin
      control_output_d = hex_seg;
    end
    digit_select_d = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((presc_d != '0) && (IDX_W'(k) == idx_d)) begin
        digit_select_d[k] = 1'b0;
      end
    end
  end

  // State and output registers; reset blanks the display immediately and drops pending data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q          <= '0;
      idx_q            <= '0;
      shadow_q         <= '0;
      active_q         <= '0;
      pending_q        <= 1'b0;
      frame_done_q     <= 1'b0;
      digit_select_q   <= '1;
      control_output_q <= SEG_BLANK;
    end else begin
      presc_q          <= presc_d;
      idx_q            <= idx_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      pending_q        <= pending_d;
      frame_done_q     <= frame_done_d;
      digit_select_q   <= digit_select_d;
      control_output_q <= control_output_d;
    end
  end

  assign bus.digitSelect   = digit_select_q;
  assign bus.controlOutput = control_output_q;
  assign bus.frameDone     = frame_done_q;
  assign bus.pending       = pending_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb_seven_segment_scan_driver: self-checking bench, CLK_DIV=4, NUM_DIGITS=4.
// Reference model works from a cycle count since reset release (slot = count / CLK_DIV).
module tb_seven_segment_scan_driver;

  localparam int unsigned ND    = 4;
  localparam int unsigned CDIV  = 4;
  localparam int unsigned FRAME = ND * CDIV;

  logic clock;
  logic reset;

  int unsigned checks;
  int unsigned errors;

  // reference model state
  int unsigned m_cyc;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_pending;
  logic        m_en;
  logic [3:0]  m_blank;
  logic [6:0]  hex_ref [16];

  typedef struct {
    logic             en;
    logic [3:0]       blank;
    logic [15:0]      data;
    logic [3:0][6:0]  exp;
  } vec_t;
  vec_t vecs [9];

  seven_segment_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scan_driver #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (CDIV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int unsigned k);
    logic [15:0] v;
    v = m_active >> (4 * k);
    if (!m_en) return 7'b0111111;
    if (m_blank[k]) return 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && v == 16'h0) return 7'b1111111;
`endif
    return hex_ref[v[3:0]];
  endfunction

  // Apply the spec's load/wrap rules at one clock edge.
  task automatic model_edge();
    logic wrap;
    wrap = (m_cyc % FRAME) == FRAME - 1;
    m_en    = bus.enable;
    m_blank = bus.blankMask;
    if (bus.load) begin
      m_shadow = bus.dataInput;
      if (wrap) begin
        m_active  = bus.dataInput;
        m_pending = 1'b0;
      end else begin
        m_pending = 1'b1;
      end
    end else if (wrap && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    int unsigned pos, dig;
    logic [3:0] one, ds;
    pos = m_cyc % CDIV;
    dig = (m_cyc / CDIV) % ND;
    one = 4'b0001;
    ds  = (pos == 0) ? 4'hF : ~(one << dig);
    check("digitSelect", 32'(bus.digitSelect), 32'(ds));
    check("controlOutput", 32'(bus.controlOutput), 32'(ref_seg(dig)));
    check("frameDone", 32'(bus.frameDone), 32'((m_cyc != 0) && (m_cyc % FRAME == 0)));
    check("pending", 32'(bus.pending), 32'(m_pending));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_cyc     = 0;
    m_shadow  = '0;
    m_active  = '0;
    m_pending = 1'b0;
  endtask

  task automatic set_vec(input int unsigned i, input logic en, input logic [3:0] blank,
                         input logic [15:0] data, input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
    vecs[i].en    = en;
    vecs[i].blank = blank;
    vecs[i].data  = data;
    vecs[i].exp   = {d3, d2, d1, d0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hex_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    set_vec(0, 1'b1, 4'b0000, 16'h1A2F, 7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110);
    set_vec(1, 1'b0, 4'b0100, 16'h1A2F, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    set_vec(2, 1'b1, 4'b0100, 16'h1A2F, 7'b1111001, 7'b1111111, 7'b0100100, 7'b0001110);
`ifdef LEADING_ZERO_BLANK_EN
    set_vec(3, 1'b1, 4'b0000, 16'h0050, 7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000);
    set_vec(4, 1'b1, 4'b0000, 16'h0000, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);
`else
    set_vec(3, 1'b1, 4'b0000, 16'h0050, 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000);
    set_vec(4, 1'b1, 4'b0000, 16'h0000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif
    set_vec(5, 1'b1, 4'b0000, 16'hC3B8, 7'b1000110, 7'b0110000, 7'b0000011, 7'b0000000);
    set_vec(6, 1'b1, 4'b0000, 16'h7D64, 7'b1111000, 7'b0100001, 7'b0000010, 7'b0011001);
    set_vec(7, 1'b1, 4'b0000, 16'hE590, 7'b0000110, 7'b0010010, 7'b0010000, 7'b1000000);
    set_vec(8, 1'b1, 4'b1001, 16'h0506, 7'b1111111, 7'b0010010, 7'b1000000, 7'b1111111);

    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.load      = 1'b0;
    bus.dataInput = '0;
    bus.blankMask = '0;
    model_reset();
    m_en    = 1'b1;
    m_blank = '0;

    // reset state, checked before any clock edge has occurred under reset
    #2 reset = 1'b1;
    #1;
    check("rst_digitSelect", 32'(bus.digitSelect), 32'hF);
    check("rst_controlOutput", 32'(bus.controlOutput), 32'h7F);
    check("rst_frameDone", 32'(bus.frameDone), 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();

    // idle scan after reset: two frames of zeros
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // table-driven vectors: load mid-frame, reach wrap, then check one full frame
    for (int v = 0; v < 9; v++) begin
      while ((m_cyc % FRAME) != 5) tick();
      bus.enable    = vecs[v].en;
      bus.blankMask = vecs[v].blank;
      bus.dataInput = vecs[v].data;
      bus.load      = 1'b1;
      tick();
      bus.load      = 1'b0;
      check("tbl_pending", 32'(bus.pending), 32'h1);
      for (int i = 0; i < FRAME && (m_cyc % FRAME) != 0; i++) tick();
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if ((m_cyc % CDIV) == 1)
          check("tbl_seg", 32'(bus.controlOutput), 32'(vecs[v].exp[(m_cyc / CDIV) % ND]));
      end
    end

    // load exactly on the wrap edge: bypass, pending stays 0
    bus.enable    = 1'b1;
    bus.blankMask = '0;
    bus.dataInput = 16'h1111;
    bus.load      = 1'b1;
    while ((m_cyc % FRAME) != 8) tick();
    bus.load      = 1'b0;
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != FRAME - 1; i++) tick();
    bus.dataInput = 16'h0009;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
    check("wrap_load_pending", 32'(bus.pending), 32'h0);
    check("wrap_load_seg", 32'(bus.controlOutput), 32'h10);
    check("wrap_load_frameDone", 32'(bus.frameDone), 32'h1);
    for (int i = 0; i < FRAME; i++) tick();

    // repeated loads before a wrap: last one wins
    while ((m_cyc % FRAME) != 2) tick();
    bus.dataInput = 16'h4321;
    bus.load      = 1'b1;
    tick();
    bus.dataInput = 16'hBEEF;
    tick();
    bus.load      = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // reset mid-slot with pending data
    while ((m_cyc % FRAME) != 3) tick();
    bus.dataInput = 16'h8765;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
    tick();
    tick();
    check("pre_rst_pending", 32'(bus.pending), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_digitSelect", 32'(bus.digitSelect), 32'hF);
    check("mid_rst_controlOutput", 32'(bus.controlOutput), 32'h7F);
    check("mid_rst_pending", 32'(bus.pending), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus.enable    = ($urandom_range(7) != 0);
      bus.load      = ($urandom_range(7) == 0);
      bus.dataInput = 16'($urandom);
      if ($urandom_range(3) == 0)
        bus.blankMask = 4'($urandom);
      else if ($urandom_range(3) == 0)
        bus.blankMask = '0;
      tick();
    end
    bus.load = 1'b0;
    for (int i = 0; i < FRAME; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
